// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings, FSM states and lane helpers for the data memory responder
// Load types LB/LH/LW/LBU/LHU, store types SB/SH/SW, state_t, byte-enable,
// store-lane replication, load extension and misalignment detection.
package mem_pkg;
  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LW  = 3'b010;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;
  localparam logic [1:0] ST_SB  = 2'b00;
  localparam logic [1:0] ST_SH  = 2'b01;
  localparam logic [1:0] ST_SW  = 2'b10;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  function automatic logic [3:0] byte_en(input logic [1:0] st, input logic [1:0] a);
    return st == ST_SB ? 4'b0001 << a :
           st == ST_SH ? (a[1] ? 4'b1100 : 4'b0011) :
           st == ST_SW ? 4'b1111 : 4'b0000;
  endfunction

  function automatic logic [31:0] wdata_rep(input logic [1:0] st, input logic [31:0] d);
    return st == ST_SB ? {4{d[7:0]}} : st == ST_SH ? {2{d[15:0]}} : d;
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] lt, input logic [31:0] w, input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {a, 3'b000});
    h = 16'(w >> {a[1], 4'b0000});
    return lt == LT_LB  ? {{24{b[7]}}, b} :
           lt == LT_LBU ? {24'b0, b} :
           lt == LT_LH  ? {{16{h[15]}}, h} :
           lt == LT_LHU ? {16'b0, h} : w;
  endfunction

  function automatic logic misaligned(input logic wr, input logic [2:0] lt, input logic [1:0] st, input logic [1:0] a);
    logic half;
    logic word;
    half = wr ? st == ST_SH : (lt == LT_LH || lt == LT_LHU);
    word = wr ? st == ST_SW : !(lt == LT_LB || lt == LT_LBU || half);
    return (half && a[0]) || (word && a != 2'b00);
  endfunction
endpackage

// File: rtl/mem_word_array.sv
// mem_word_array: DEPTH x 32 synchronous RAM with byte write enables and registered read
// clk clock; i_en access strobe; i_be byte write enables; i_idx word index;
// i_wdata lane-aligned write data; o_rdata word read at the last enabled edge.
module mem_word_array import mem_pkg::*; #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     i_en,
  input  logic [3:0]               i_be,
  input  logic [$clog2(DEPTH)-1:0] i_idx,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              o_rdata
);
  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk)
    if (i_en) begin
      for (int i = 0; i < 4; i++)
        if (i_be[i]) r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
      o_rdata <= r_mem[i_idx];
    end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: MEM-stage load/store responder with fixed access latency
// clk; rst sync active-low; req_valid/req_ready handshake; req_write, req_load_type,
// req_store_type, req_addr, req_wdata request fields; resp_valid one-cycle pulse with
// resp_rdata and resp_err; stall holds the pipeline while an access is in flight.
// Define MEM_MISALIGN_TRAP_EN to flag misaligned accesses instead of force-aligning them.
module data_mem_responder import mem_pkg::*; #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_load_type,
  input  logic [1:0]  req_store_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic            r_write;
  logic [2:0]      r_ltype;
  logic [1:0]      r_stype;
  logic [AW+1:0]   r_addr;
  logic [31:0]     r_wdata;
  logic            w_last;
  logic            w_trap;
  logic [3:0]      w_be;
  logic [31:0]     w_ram_rdata;
  logic            w_unused;

  assign w_unused = &{1'b0, req_addr[31:AW+2]};

  always_ff @(posedge clk)
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= r_state == ACCESS ? r_cnt + 1'b1 : '0;
    end

  always_ff @(posedge clk)
    if (req_valid && req_ready) begin
      r_write <= req_write;
      r_ltype <= req_load_type;
      r_stype <= req_store_type;
      r_addr  <= req_addr[AW+1:0];
      r_wdata <= req_wdata;
    end

  assign w_last = r_state == ACCESS && r_cnt == CW'(WAIT_CYCLES);

  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE   ? (req_valid ? ACCESS : IDLE) :
             r_state == ACCESS ? (w_last ? RESP : ACCESS) : IDLE;
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_trap = misaligned(r_write, r_ltype, r_stype, r_addr[1:0]);
`else
  assign w_trap = 1'b0;
`endif

  assign w_be = w_last && r_write && !w_trap ? byte_en(r_stype, r_addr[1:0]) : 4'b0000;

  mem_word_array #(.DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .i_en    (w_last),
    .i_be    (w_be),
    .i_idx   (r_addr[AW+1:2]),
    .i_wdata (wdata_rep(r_stype, r_wdata)),
    .o_rdata (w_ram_rdata)
  );

  assign req_ready  = r_state == IDLE;
  assign resp_valid = r_state == RESP;
  assign stall      = r_state != IDLE || req_valid;
  assign resp_err   = resp_valid && w_trap;
  assign resp_rdata = resp_valid && !r_write && !w_trap ? extend(r_ltype, w_ram_rdata, r_addr[1:0]) : 32'h0;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized scoreboard bench for data_mem_responder
module tb_data_mem_responder;
  localparam int W = 2;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 0;
  logic        rst = 0;
  logic        req_valid = 0, req_ready, req_write = 0;
  logic [2:0]  req_load_type = 0;
  logic [1:0]  req_store_type = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        resp_valid, resp_err, stall;
  logic [31:0] resp_rdata;

  logic        z_valid = 0, z_ready, z_write = 0;
  logic [2:0]  z_lt = 3'b010;
  logic [1:0]  z_st = 2'b10;
  logic [31:0] z_addr = 0, z_wdata = 0;
  logic        z_resp_valid, z_err, z_stall;
  logic [31:0] z_rdata;

  int   checks = 0, errors = 0, cyc = 0, last_acc = 0;
  bit   mon_en = 0;
  exp_t q[$];
  logic [7:0] mem_b [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_load_type(req_load_type), .req_store_type(req_store_type),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .stall(stall)
  );

  data_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(z_valid), .req_ready(z_ready),
    .req_write(z_write), .req_load_type(z_lt), .req_store_type(z_st),
    .req_addr(z_addr), .req_wdata(z_wdata), .resp_valid(z_resp_valid),
    .resp_rdata(z_rdata), .resp_err(z_err), .stall(z_stall)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic void model(input bit wr, input logic [2:0] lt, input logic [1:0] st,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output logic [31:0] rd, output logic err);
    int sz, base, b;
    logic [31:0] v;
    b  = int'(addr[7:0]);
    sz = wr ? (st == 2'd0 ? 1 : st == 2'd1 ? 2 : st == 2'd2 ? 4 : 0)
            : (lt == 3'd0 || lt == 3'd4 ? 1 : lt == 3'd1 || lt == 3'd5 ? 2 : 4);
    rd  = 0;
    err = 0;
    if (sz == 0) return;
`ifdef MEM_MISALIGN_TRAP_EN
    if (b % sz != 0) begin
      err = 1;
      return;
    end
`endif
    base = b - b % sz;
    if (wr) begin
      for (int i = 0; i < sz; i++) mem_b[base + i] = wd[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < sz; i++) v = v | (32'(mem_b[base + i]) << (8 * i));
      if (sz < 4 && (lt == 3'd0 || lt == 3'd1) && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
      rd = v;
    end
  endfunction

  task automatic issue(input bit wr, input logic [2:0] lt, input logic [1:0] st,
                       input logic [31:0] addr, input logic [31:0] wd, input bit hold, input bit chk_b2b);
    exp_t e;
    int n;
    req_write = wr; req_load_type = lt; req_store_type = st; req_addr = addr; req_wdata = wd;
    req_valid = 1;
    n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_wait", {31'b0, req_ready}, 32'd1);
    if (!req_ready) begin
      req_valid = 0;
      return;
    end
    @(posedge clk); #1;
    if (chk_b2b) chk("b2b_accept_cycle", cyc, last_acc + W + 3);
    last_acc = cyc;
    model(wr, lt, st, addr, wd, e.rd, e.err);
    e.cyc = cyc + W + 1;
    q.push_back(e);
    req_write = ~wr; req_addr = ~addr; req_wdata = ~wd;
    if (!hold) req_valid = 0;
  endtask

  always @(negedge clk)
    if (rst) begin
      if (mon_en) begin
        chk("req_ready", {31'b0, req_ready}, {31'b0, q.size() == 0});
        chk("stall", {31'b0, stall}, {31'b0, q.size() != 0 || req_valid});
      end
      if (resp_valid) begin
        if (q.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("resp_rdata", resp_rdata, e.rd);
          chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
          chk("resp_latency", cyc, e.cyc);
        end
      end else if (q.size() != 0 && cyc > q[0].cyc) begin
        chk("resp_missing", 32'd0, 32'd1);
        void'(q.pop_front());
      end
    end

  task automatic z_op(input bit wr, input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] exp);
    int n;
    z_write = wr; z_addr = addr; z_wdata = wd; z_valid = 1;
    chk("w0_ready", {31'b0, z_ready}, 32'd1);
    @(posedge clk); #1;
    z_valid = 0;
    n = 0;
    while (!z_resp_valid && n < 10) begin
      @(posedge clk); #1; n++;
    end
    chk("w0_latency", n + 1, 32'd2);
    chk("w0_rdata", z_rdata, exp);
    chk("w0_err", {31'b0, z_err}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] r1, r2;
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    rst = 1;
    @(posedge clk); #1;
    mon_en = 1;
    for (int i = 0; i < 64; i++) issue(1, 3'b010, 2'b10, 32'(i * 4), $urandom, 0, 0);
    issue(1, 3'b010, 2'b10, 32'h10, 32'hDEADBEEF, 0, 0);
    issue(0, 3'b010, 2'b10, 32'h10, 32'h0, 0, 0);
    issue(1, 3'b010, 2'b10, 32'h20, 32'h0, 0, 0);
    issue(1, 3'b010, 2'b00, 32'h21, 32'h80, 0, 0);
    issue(0, 3'b000, 2'b10, 32'h21, 32'h0, 0, 0);
    issue(0, 3'b100, 2'b10, 32'h21, 32'h0, 0, 0);
    issue(0, 3'b010, 2'b10, 32'h20, 32'h0, 0, 0);
    issue(1, 3'b010, 2'b10, 32'h30, 32'h0, 0, 0);
    issue(1, 3'b010, 2'b01, 32'h32, 32'h8001, 0, 0);
    issue(0, 3'b001, 2'b10, 32'h32, 32'h0, 0, 0);
    issue(0, 3'b101, 2'b10, 32'h32, 32'h0, 0, 0);
    issue(0, 3'b010, 2'b10, 32'h30, 32'h0, 0, 0);
    issue(0, 3'b010, 2'b10, 32'h06, 32'h0, 0, 0);
    issue(1, 3'b010, 2'b10, 32'h06, 32'h55AA33CC, 0, 0);
    issue(0, 3'b010, 2'b10, 32'h04, 32'h0, 0, 0);
    issue(1, 3'b010, 2'b11, 32'h08, 32'hFFFFFFFF, 0, 0);
    issue(0, 3'b111, 2'b10, 32'h08, 32'h0, 0, 0);
    issue(1, 3'b010, 2'b10, 32'h0000_1010, 32'hCAFEF00D, 0, 0);
    issue(0, 3'b010, 2'b10, 32'h10, 32'h0, 1, 0);
    issue(0, 3'b001, 2'b10, 32'h12, 32'h0, 1, 1);
    issue(0, 3'b000, 2'b10, 32'h13, 32'h0, 0, 1);
    for (int i = 0; i < 300; i++) begin
      r1 = $urandom;
      r2 = $urandom;
      issue(r1[0], r1[3:1], r1[5:4], {r2[31:12], 4'b0000, r2[7:0]}, $urandom, r1[6], 0);
    end
    req_valid = 0;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("drain", q.size(), 32'd0);
    mon_en = 0;
    req_write = 1; req_store_type = 2'b10; req_addr = 32'h40; req_wdata = 32'h12345678; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    rst = 0;
    @(posedge clk); #1;
    chk("midrst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("midrst_resp_rdata", resp_rdata, 32'd0);
    chk("midrst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("midrst_stall", {31'b0, stall}, 32'd0);
    rst = 1;
    @(posedge clk); #1;
    mon_en = 1;
    issue(0, 3'b010, 2'b10, 32'h40, 32'h0, 0, 0);
    z_op(1, 32'h80, 32'hA5A5_0F0F, 32'h0);
    z_op(0, 32'h80, 32'h0, 32'hA5A5_0F0F);
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("final_drain", q.size(), 32'd0);
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
